// File: rtl/riscv_aes_rd.sv
// riscv_aes_rd: fetches NUM_WORDS consecutive 32-bit words from data memory into one AES operand.
// Latency: two cycles per word at zero wait; done_out pulses 2*NUM_WORDS+1 cycles after start.
// Backpressure: req/address held until gnt_in, rvalid_in awaited indefinitely, core halted throughout.
// Optional macro RISCV_AES_RD_BSWAP_EN: byte-reverse every fetched word before storing it.
module riscv_aes_rd #(
   parameter int NUM_WORDS   = 4,
   parameter int ADDR_STRIDE = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start_aes_rd,
   input  logic [31:0]             address_in,
   input  logic                    gnt_in,
   input  logic                    rvalid_in,
   input  logic [31:0]             rdata_in,
   output logic                    req_out,
   output logic [31:0]             address_out,
   output logic                    halt_en_out,
   output logic                    done_out,
   output logic [32*NUM_WORDS-1:0] data_out
);

   localparam int               CNT_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_WORDS - 1);

   typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [CNT_W-1:0]        r_cnt;
   logic [32*NUM_WORDS-1:0] r_buf;
   logic [32*NUM_WORDS-1:0] w_buf_nxt;
   logic [31:0]             w_word;
   logic [31:0]             w_base;
   logic                    w_last;

   // The low two address bits are forced to zero so every request is word aligned.
   assign w_base = address_in & 32'hFFFF_FFFC;
   assign w_last = (r_cnt == LAST_CNT);

`ifdef RISCV_AES_RD_BSWAP_EN
   assign w_word = {rdata_in[7:0], rdata_in[15:8], rdata_in[23:16], rdata_in[31:24]};
`else
   assign w_word = rdata_in;
`endif

   // Merge the arriving word into its slot so the last word is part of the operand on the same edge.
   always_comb begin
      w_buf_nxt = r_buf;
      for (int i = 0; i < NUM_WORDS; i++) begin
         if (r_cnt == CNT_W'(i)) begin
            w_buf_nxt[i*32 +: 32] = w_word;
         end
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic: one request outstanding at a time, grant before data.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (start_aes_rd) w_state_nxt = REQ;
         REQ:     if (gnt_in)       w_state_nxt = WAIT_R;
         WAIT_R:  if (rvalid_in)    w_state_nxt = w_last ? DONE : REQ;
         DONE:                      w_state_nxt = IDLE;
         default:                   w_state_nxt = IDLE;
      endcase
   end

   // Registered outputs, word counter and assembly buffer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_out     <= 1'b0;
         address_out <= 32'h0;
         halt_en_out <= 1'b0;
         done_out    <= 1'b0;
         data_out    <= '0;
         r_cnt       <= '0;
         r_buf       <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start_aes_rd) begin
                  req_out     <= 1'b1;
                  address_out <= w_base;
                  halt_en_out <= 1'b1;
                  r_cnt       <= '0;
               end
            end
            REQ: begin
               // Any rvalid seen here belongs to nobody; only the grant is consumed.
               if (gnt_in) begin
                  req_out <= 1'b0;
               end
            end
            WAIT_R: begin
               if (rvalid_in) begin
                  r_buf <= w_buf_nxt;
                  if (w_last) begin
                     data_out <= w_buf_nxt;
                     done_out <= 1'b1;
                  end else begin
                     // address_out already equals base + cnt*stride, so one stride step reaches the next word.
                     r_cnt       <= r_cnt + 1'b1;
                     address_out <= address_out + 32'(ADDR_STRIDE);
                     req_out     <= 1'b1;
                  end
               end
            end
            DONE: begin
               done_out    <= 1'b0;
               halt_en_out <= 1'b0;
            end
            default: begin
               req_out     <= 1'b0;
               halt_en_out <= 1'b0;
               done_out    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_riscv_aes_rd.sv
// tb_riscv_aes_rd: directed vectors for the AES operand fetch engine.
// Latency: cycle-accurate checks of req/address/halt/done/data against hand-computed tables.
// Backpressure: memory model grants in the request cycle unless a stall is scheduled.
module tb_riscv_aes_rd;

   logic         clk;
   logic         rst;
   logic         start_aes_rd;
   logic [31:0]  address_in;
   logic         gnt_in;
   logic         rvalid_in;
   logic [31:0]  rdata_in;
   logic         req_out;
   logic [31:0]  address_out;
   logic         halt_en_out;
   logic         done_out;
   logic [127:0] data_out;

   int n_checks = 0;
   int n_errors = 0;
   logic [127:0] prev_data;

   riscv_aes_rd #(.NUM_WORDS(4), .ADDR_STRIDE(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .start_aes_rd (start_aes_rd),
      .address_in   (address_in),
      .gnt_in       (gnt_in),
      .rvalid_in    (rvalid_in),
      .rdata_in     (rdata_in),
      .req_out      (req_out),
      .address_out  (address_out),
      .halt_en_out  (halt_en_out),
      .done_out     (done_out),
      .data_out     (data_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0]  addr_in;
      logic [127:0] words;       // memory contents, word i at [i*32+:32]
      logic [127:0] exp_addrs;   // expected request address for word i
      logic [127:0] exp_data;    // expected operand with words stored as received
      logic [7:0]   stall_word;  // word whose grant is withheld (255 = none)
      logic [7:0]   stall_cyc;
      logic [7:0]   extra_start; // cycle of an ignored second start (0 = none)
      logic         spurious_rv; // raise rvalid together with every grant
      logic [7:0]   exp_done;    // cycle in which done_out must pulse
   } vec_t;

   vec_t vecs [4];

   function automatic logic [31:0] bsw(input logic [31:0] w);
`ifdef RISCV_AES_RD_BSWAP_EN
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
      return w;
`endif
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, " req"},  {127'h0, req_out},     128'h0);
      check({tag, " addr"}, {96'h0, address_out},  128'h0);
      check({tag, " halt"}, {127'h0, halt_en_out}, 128'h0);
      check({tag, " done"}, {127'h0, done_out},    128'h0);
      check({tag, " data"}, data_out,              128'h0);
   endtask

   // Start at cycle 0 and check every output each cycle until two cycles past the expected done.
   task automatic run_fetch(input vec_t v, input string tag);
      int           ngnt;
      int           stall_n;
      int           done_c;
      logic         pend;
      logic [31:0]  pend_dat;
      logic [127:0] exp_data;
      ngnt     = 0;
      stall_n  = 0;
      pend     = 1'b0;
      pend_dat = 32'h0;
      done_c   = int'(v.exp_done);
      for (int i = 0; i < 4; i++) exp_data[i*32 +: 32] = bsw(v.exp_data[i*32 +: 32]);
      for (int c = 0; c <= done_c + 2; c++) begin
         @(negedge clk);
         check($sformatf("%s halt c%0d", tag, c), {127'h0, halt_en_out}, {127'h0, (c >= 1 && c <= done_c)});
         check($sformatf("%s done c%0d", tag, c), {127'h0, done_out},    {127'h0, (c == done_c)});
         if (c < done_c) check($sformatf("%s data hold c%0d", tag, c), data_out, prev_data);
         else            check($sformatf("%s data c%0d", tag, c),      data_out, exp_data);
         if (req_out) begin
            if (ngnt < 4) check($sformatf("%s addr c%0d", tag, c), {96'h0, address_out}, {96'h0, v.exp_addrs[ngnt*32 +: 32]});
            else          check($sformatf("%s extra req c%0d", tag, c), 128'h1, 128'h0);
         end
         start_aes_rd = (c == 0) || (v.extra_start != 8'd0 && c == int'(v.extra_start));
         address_in   = (c == 0) ? v.addr_in : 32'h5000_0000;
         rvalid_in    = pend;
         rdata_in     = pend_dat;
         pend         = 1'b0;
         gnt_in       = 1'b0;
         if (req_out && ngnt < 4) begin
            if (ngnt == int'(v.stall_word) && stall_n < int'(v.stall_cyc)) begin
               stall_n++;
            end else begin
               gnt_in   = 1'b1;
               pend     = 1'b1;
               pend_dat = v.words[ngnt*32 +: 32];
               ngnt++;
               if (v.spurious_rv) begin
                  rvalid_in = 1'b1;
                  rdata_in  = 32'hBAD0_BAD0;
               end
            end
         end
      end
      check({tag, " grant count"}, 128'(ngnt), 128'd4);
      prev_data = exp_data;
   endtask

   function automatic vec_t mk(input logic [31:0] a, input logic [127:0] w, input logic [127:0] ea,
                               input logic [127:0] ed, input logic [7:0] sw, input logic [7:0] sc,
                               input logic [7:0] xs, input logic sp, input logic [7:0] dn);
      vec_t v;
      v.addr_in = a;  v.words = w;  v.exp_addrs = ea;  v.exp_data = ed;
      v.stall_word = sw;  v.stall_cyc = sc;  v.extra_start = xs;  v.spurious_rv = sp;  v.exp_done = dn;
      return v;
   endfunction

   initial begin
      // zero-wait fetch
      vecs[0] = mk(32'h0000_1000,
                   128'h44444444_33333333_22222222_11111111,
                   128'h0000100C_00001008_00001004_00001000,
                   128'h44444444_33333333_22222222_11111111,
                   8'd255, 8'd0, 8'd0, 1'b0, 8'd9);
      // grant withheld for 3 cycles on word 2
      vecs[1] = mk(32'h0000_1000,
                   128'h88888888_77777777_66666666_55555555,
                   128'h0000100C_00001008_00001004_00001000,
                   128'h88888888_77777777_66666666_55555555,
                   8'd2, 8'd3, 8'd0, 1'b0, 8'd12);
      // misaligned base with address wrap, rvalid asserted alongside each grant
      vecs[2] = mk(32'hFFFF_FFFB,
                   128'hCAFEF00D_89ABCDEF_01234567_DEADBEEF,
                   128'h00000004_00000000_FFFFFFFC_FFFFFFF8,
                   128'hCAFEF00D_89ABCDEF_01234567_DEADBEEF,
                   8'd255, 8'd0, 8'd0, 1'b1, 8'd9);
      // second start at cycle 4 must be ignored
      vecs[3] = mk(32'h0000_2000,
                   128'h90A0B0C0_50607080_10203040_0A0B0C0D,
                   128'h0000200C_00002008_00002004_00002000,
                   128'h90A0B0C0_50607080_10203040_0A0B0C0D,
                   8'd255, 8'd0, 8'd4, 1'b0, 8'd9);

      rst          = 1'b1;
      start_aes_rd = 1'b0;
      address_in   = 32'h0;
      gnt_in       = 1'b0;
      rvalid_in    = 1'b0;
      rdata_in     = 32'h0;
      prev_data    = 128'h0;

      repeat (2) @(negedge clk);
      check_idle_outputs("in reset");
      rst = 1'b0;
      @(negedge clk);
      check_idle_outputs("after reset");

      for (int k = 0; k < 4; k++) run_fetch(vecs[k], $sformatf("v%0d", k));

`ifdef RISCV_AES_RD_BSWAP_EN
      check("bswap word0", {96'h0, data_out[31:0]}, 128'h0D0C0B0A);
`else
      check("raw word0", {96'h0, data_out[31:0]}, 128'h0A0B0C0D);
`endif

      // reset asserted while waiting for the read data of word 1
      @(negedge clk);
      start_aes_rd = 1'b1;
      address_in   = 32'h0000_3000;
      @(negedge clk);
      start_aes_rd = 1'b0;
      check("mid req w0", {127'h0, req_out}, 128'h1);
      gnt_in = 1'b1;
      @(negedge clk);
      gnt_in    = 1'b0;
      rvalid_in = 1'b1;
      rdata_in  = 32'h1234_5678;
      @(negedge clk);
      rvalid_in = 1'b0;
      check("mid req w1",  {127'h0, req_out},    128'h1);
      check("mid addr w1", {96'h0, address_out}, 128'h3004);
      gnt_in = 1'b1;
      @(negedge clk);
      gnt_in = 1'b0;
      check("mid halt", {127'h0, halt_en_out}, 128'h1);
      rst = 1'b1;
      #1;
      check_idle_outputs("async reset");
      @(negedge clk);
      rst       = 1'b0;
      rvalid_in = 1'b1;
      gnt_in    = 1'b1;
      rdata_in  = 32'hFFFF_FFFF;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         rvalid_in = 1'b0;
         gnt_in    = 1'b0;
         check_idle_outputs($sformatf("stray c%0d", c));
      end
      prev_data = 128'h0;
      run_fetch(vecs[0], "post-reset");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
